// File: rtl/seg_pkg.sv
// Shared types and constants for the 4-digit seven-segment scan controller.
package seg_pkg;

  localparam int NDIG = 4;

  // All anodes off (active-low drive).
  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  // Active-low one-cold anode pattern selecting digit idx.
  function automatic logic [3:0] an_sel(input logic [1:0] idx);
    an_sel = AN_OFF & ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Digit-slot prescaler: counts 0..CLK_DIV-1 and flags the last cycle of a slot.
module scan_tick_gen #(
  parameter int CLK_DIV = 100000,
  parameter int CW      = $clog2(CLK_DIV)
) (
  input  logic          clk,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          slot_end
);

  // Last cycle of the current digit slot.
  always_comb begin
    slot_end = (cnt == CW'(CLK_DIV - 1)) ? 1'b1 : 1'b0;
  end

  // Free-running prescaler, wraps to zero at slot end.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode display with
// per-slot dead-time, leading-zero blanking and a frame-synchronous double buffer.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_DIV   = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        load,
  input  logic [15:0] din,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  x,
  output logic [3:0]  an_n,
  output logic        dp_n,
  output logic        frame,
  output logic        pending
);

  localparam int   CW       = $clog2(CLK_DIV);
  localparam int   BEND     = (BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0;
  localparam logic NO_BLANK = (BLANK_CYC == 0) ? 1'b1 : 1'b0;

  logic [CW-1:0] cnt_s;
  logic          slot_end_s;
  logic [1:0]    idx_r;
  state_t        state_r;
  state_t        state_nxt_s;
  logic [15:0]   active_r;
  logic [3:0]    active_dp_r;
  logic [15:0]   pend_r;
  logic [3:0]    pend_dp_r;
  logic          wrap_s;
  logic          showing_s;
  logic          upper_zero_s;
  logic          supp_s;
  logic [3:0]    nib_s;

  scan_tick_gen #(
    .CLK_DIV (CLK_DIV),
    .CW      (CW)
  ) u_tick (
    .clk      (clk),
    .clr      (clr),
    .cnt      (cnt_s),
    .slot_end (slot_end_s)
  );

  // Digit index advances once per slot; 3 wraps to 0.
  always_ff @(posedge clk) begin
    if (clr) begin
      idx_r <= 2'd0;
    end else if (slot_end_s) begin
      idx_r <= idx_r + 2'd1;
    end else begin
      idx_r <= idx_r;
    end
  end

  // Dead-time / show state register.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r <= BLANK;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: leave BLANK after the dead-time, return to BLANK at slot end.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      BLANK: begin
        if (NO_BLANK || (cnt_s == CW'(BEND))) begin
          state_nxt_s = SHOW;
        end else begin
          state_nxt_s = BLANK;
        end
      end
      SHOW: begin
        if (!NO_BLANK && slot_end_s) begin
          state_nxt_s = BLANK;
        end else begin
          state_nxt_s = SHOW;
        end
      end
      default: state_nxt_s = BLANK;
    endcase
  end

  // Current nibble and leading-zero detection for the slot being scanned.
  always_comb begin
    wrap_s       = slot_end_s & (idx_r == 2'd3);
    showing_s    = (state_r == SHOW) | NO_BLANK;
    nib_s        = 4'h0;
    upper_zero_s = 1'b0;
    case (idx_r)
      2'd0: begin
        nib_s        = active_r[3:0];
        upper_zero_s = 1'b0;
      end
      2'd1: begin
        nib_s        = active_r[7:4];
        upper_zero_s = (active_r[15:4] == 12'h000);
      end
      2'd2: begin
        nib_s        = active_r[11:8];
        upper_zero_s = (active_r[15:8] == 8'h00);
      end
      2'd3: begin
        nib_s        = active_r[15:12];
        upper_zero_s = (active_r[15:12] == 4'h0);
      end
      default: begin
        nib_s        = 4'h0;
        upper_zero_s = 1'b0;
      end
    endcase
    supp_s = blank_lz & upper_zero_s;
  end

  // Registered display outputs, one cycle behind idx/state/cnt.
  always_ff @(posedge clk) begin
    if (clr) begin
      x     <= 4'h0;
      an_n  <= AN_OFF;
      dp_n  <= 1'b1;
      frame <= 1'b0;
    end else begin
      x     <= nib_s;
      frame <= wrap_s;
      if (showing_s && !supp_s) begin
        an_n <= an_sel(idx_r);
        dp_n <= ~active_dp_r[idx_r];
      end else begin
        an_n <= AN_OFF;
        dp_n <= 1'b1;
      end
    end
  end

  // Double buffer: loads go to pend, pend moves to active only at the frame wrap.
  always_ff @(posedge clk) begin
    if (clr) begin
      active_r    <= 16'h0000;
      active_dp_r <= 4'h0;
      pend_r      <= 16'h0000;
      pend_dp_r   <= 4'h0;
      pending     <= 1'b0;
    end else begin
      if (wrap_s && pending) begin
        active_r    <= pend_r;
        active_dp_r <= pend_dp_r;
      end
      if (load) begin
        pend_r    <= din;
        pend_dp_r <= dp_in;
        pending   <= 1'b1;
      end else if (wrap_s) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios plus random traffic,
// compared cycle by cycle against a time-based reference model.
module tb_seg_scan_ctrl;

  localparam int CD   = 8;
  localparam int BC   = 2;
  localparam int FRM  = 4 * CD;

  logic        clk = 1'b0;
  logic        clr;
  logic        load;
  logic [15:0] din;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  x;
  logic [3:0]  an_n;
  logic        dp_n;
  logic        frame;
  logic        pending;

  int checks   = 0;
  int failures = 0;

  // Reference model: display time since reset plus buffer contents.
  int          mt;
  logic [15:0] m_active;
  logic [3:0]  m_active_dp;
  logic [15:0] m_pend;
  logic [3:0]  m_pend_dp;
  logic        m_pending;
  logic [3:0]  e_x;
  logic [3:0]  e_an;
  logic        e_dp;
  logic        e_frame;
  logic        e_pending;

  seg_scan_ctrl #(
    .CLK_DIV   (CD),
    .BLANK_CYC (BC)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .load     (load),
    .din      (din),
    .dp_in    (dp_in),
    .blank_lz (blank_lz),
    .x        (x),
    .an_n     (an_n),
    .dp_n     (dp_n),
    .frame    (frame),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h mt=%0d t=%0t", tag, obs, exp, mt, $time);
    end
  endtask

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_edge();
    int          idx;
    int          pos;
    bit          show;
    bit          supp;
    bit          wrap;
    logic [15:0] sh;
    if (clr) begin
      mt          = 0;
      m_active    = 16'h0;
      m_active_dp = 4'h0;
      m_pend      = 16'h0;
      m_pend_dp   = 4'h0;
      m_pending   = 1'b0;
      e_x         = 4'h0;
      e_an        = 4'hF;
      e_dp        = 1'b1;
      e_frame     = 1'b0;
      e_pending   = 1'b0;
    end else begin
      idx  = (mt / CD) % 4;
      pos  = mt % CD;
      show = (pos >= BC);
      sh   = m_active >> (4 * idx);
      supp = blank_lz && (idx > 0) && (sh == 16'h0);
      wrap = (pos == CD - 1) && (idx == 3);
      e_x  = sh[3:0];
      for (int i = 0; i < 4; i++) begin
        e_an[i] = !(show && !supp && (i == idx));
      end
      e_dp    = (show && !supp) ? !m_active_dp[idx] : 1'b1;
      e_frame = wrap;
      if (wrap && m_pending) begin
        m_active    = m_pend;
        m_active_dp = m_pend_dp;
      end
      if (load) begin
        m_pend    = din;
        m_pend_dp = dp_in;
        m_pending = 1'b1;
      end else if (wrap) begin
        m_pending = 1'b0;
      end
      e_pending = m_pending;
      mt++;
    end
  endtask

  // One clock cycle: apply inputs, step the model, compare after the edge.
  task automatic cyc(input logic c, input logic ld, input logic [15:0] d, input logic [3:0] dp);
    clr   = c;
    load  = ld;
    din   = d;
    dp_in = dp;
    model_edge();
    @(posedge clk);
    #1;
    chk("x", {12'h0, x}, {12'h0, e_x});
    chk("an_n", {12'h0, an_n}, {12'h0, e_an});
    chk("dp_n", {15'h0, dp_n}, {15'h0, e_dp});
    chk("frame", {15'h0, frame}, {15'h0, e_frame});
    chk("pending", {15'h0, pending}, {15'h0, e_pending});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, 16'h0, 4'h0);
    end
  endtask

  // Idle until the model's frame position equals p (at most one frame).
  task automatic run_to(input int p);
    for (int i = 0; i < FRM; i++) begin
      if ((mt % FRM) != p) begin
        cyc(1'b0, 1'b0, 16'h0, 4'h0);
      end
    end
  endtask

  initial begin
    int r;
    clr      = 1'b1;
    load     = 1'b0;
    din      = 16'h0;
    dp_in    = 4'h0;
    blank_lz = 1'b0;
    mt       = 0;

    // Reset held for three cycles, then the first slots.
    repeat (3) cyc(1'b1, 1'b0, 16'h0, 4'h0);
    run(10);

    // 0x1234 with decimal point on digit 2, over two frames.
    cyc(1'b0, 1'b1, 16'h1234, 4'b0100);
    run(2 * FRM + 8);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    cyc(1'b0, 1'b1, 16'h0042, 4'h0);
    run(2 * FRM + 4);
    cyc(1'b0, 1'b1, 16'h0000, 4'h0);
    run(2 * FRM + 4);
    blank_lz = 1'b0;

    // Second load before the wrap wins.
    cyc(1'b0, 1'b1, 16'hAAAA, 4'hF);
    run(3);
    cyc(1'b0, 1'b1, 16'hBBBB, 4'h0);
    run(2 * FRM);

    // Load in the exact wrap cycle with nothing pending.
    run_to(FRM - 1);
    cyc(1'b0, 1'b1, 16'h5555, 4'b0001);
    run(2 * FRM + 2);

    // Load while pending in the wrap cycle.
    cyc(1'b0, 1'b1, 16'h1111, 4'h0);
    run_to(FRM - 1);
    cyc(1'b0, 1'b1, 16'h2222, 4'h0);
    run(2 * FRM + 2);

    // clr mid-SHOW in the idx=2 slot with a value pending.
    cyc(1'b0, 1'b1, 16'h9876, 4'h3);
    run_to(2 * CD + 5);
    cyc(1'b1, 1'b0, 16'h0, 4'h0);
    run(FRM + 4);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 199);
      if (r < 3) begin
        blank_lz = ~blank_lz;
      end
      if (r < 14) begin
        cyc(1'b0, 1'b1, 16'($urandom), 4'($urandom));
      end else if (r == 199) begin
        cyc(1'b1, 1'b0, 16'h0, 4'h0);
      end else begin
        cyc(1'b0, 1'b0, 16'h0, 4'h0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexing scan controller for a 4-digit common-anode 7-segment display. Each digit slot presents one hex nibble on `x` to the shared hex-to-7seg decoder and asserts one active-low anode, with a dead-time gap between digits to suppress ghosting. The displayed value is double-buffered, so a new value takes effect only at a frame boundary and the display never tears. The block sits between the user/datapath logic and the board's decoder and anode pins.

Parameters:
CLK_DIV, 100000, clk cycles per digit slot; must be >= 2.
BLANK_CYC, 16, dead-time cycles at the start of each slot; must be < CLK_DIV; 0 disables dead-time.

Ports:
clk  in  1  system clock
clr  in  1  synchronous active-high reset
load  in  1  one-cycle strobe; captures din/dp_in into the pending buffer
din  in  16  four hex digits; digit 0 = din[3:0] (rightmost)
dp_in  in  4  decimal-point enables; dp_in[i] applies to digit i
blank_lz  in  1  level; 1 = blank leading zeros
x  out  4  nibble to the hex decoder
an_n  out  4  anode enables, active-low; an_n[0] = rightmost digit
dp_n  out  1  decimal point, active-low
frame  out  1  one-cycle pulse when the digit index wraps 3->0
pending  out  1  1 = loaded value not yet displayed

Behaviour:
- One clock domain (clk); clr is synchronous and active-high. The reset values below apply on the first clk edge with clr=1.
- Reset: cnt=0, idx=0, state=BLANK, active=0, active_dp=0, pend=0, pend_dp=0, pending=0, x=0, an_n=4'b1111, dp_n=1, frame=0.
- Prescaler cnt counts 0..CLK_DIV-1 and wraps to 0. A slot ends in the cycle where cnt==CLK_DIV-1.
- Digit index idx (2 bits) increments at each slot end; 3 wraps to 0. frame=1 in the cycle after the 3->0 wrap, 0 otherwise.
- FSM:
  - BLANK -> SHOW when cnt==BLANK_CYC-1.
  - SHOW -> BLANK at slot end.
  - If BLANK_CYC==0, the FSM stays in SHOW.
- Outputs are registered, one cycle after the idx/state/cnt that produces them.
  - x = active[4*idx+3 : 4*idx] in every state.
  - an_n:
    - SHOW: all ones except bit idx = 0.
    - BLANK: 4'b1111.
    - Leading-zero suppressed slot: 4'b1111.
  - dp_n:
    - SHOW and not suppressed: ~active_dp[idx].
    - Otherwise: 1.
- Leading-zero suppression: applies when blank_lz=1, idx>0 and active nibbles idx..3 are all zero. Digit 0 is never suppressed, so a value of 0 shows a single "0".
- Double buffer:
  - load=1 writes pend<=din, pend_dp<=dp_in, pending<=1.
  - Multiple loads before a wrap: the last one wins.
- Transfer at the 3->0 wrap, when pending=1: active<=pend, active_dp<=pend_dp, pending<=0. The new value is first shown in the digit-0 slot of the next frame.
- load in the same cycle as the wrap:
  - If pending was already 1, the old pend transfers, the new data is captured into pend, and pending stays 1.
  - If pending was 0, active is unchanged, the new data is captured, and pending becomes 1.
- clr mid-slot: everything returns to reset values immediately. A buffered pend is discarded.
- Width rules: cnt width = $clog2(CLK_DIV). All comparisons are unsigned. No arithmetic overflow is possible.

Decomposition:
- Shared package `seg_pkg`:
  - constant NDIG=4
  - state enum {BLANK, SHOW}
  - constant AN_OFF=4'b1111
- One natural sub-module, `scan_tick_gen`: the prescaler. Parameter CLK_DIV; outputs cnt and slot_end.
- The hex decoder is instantiated at top level, not inside this block.

Test Plan:
All scenarios use CLK_DIV=8, BLANK_CYC=2.
- Reset: hold clr 3 cycles -> an_n=1111, dp_n=1, x=0, frame=0, pending=0. After release, the first slot is BLANK for 2 cycles, then an_n=1110, x=0.
- Load 0x1234 with dp_in=4'b0100, then run 2 frames:
  - pending=1 until the wrap; frame pulses once per 32 cycles.
  - Next frame: slots show x=4,3,2,1 with an_n=1110,1101,1011,0111.
  - dp_n=0 only in the idx=2 slot.
  - an_n=1111 for the first 2 cycles of every slot.
- blank_lz=1 with 0x0042: idx2/idx3 slots keep an_n=1111. Value 0x0000 lights only digit 0 with x=0.
- Load 0xAAAA, then load 0xBBBB before the wrap: after the wrap x=B in all digits and pending=0.
- Load 0x5555 in the exact wrap cycle with pending=0: active is unchanged for that frame, pending=1. 0x5555 is displayed from the following frame.
- Assert clr mid-SHOW at idx=2 with pending=1: the next cycle gives an_n=1111, pending=0, idx=0. After release the display shows 0.
